// File: rtl/ahb2apb_bridge_p.sv
// ahb2apb_bridge_p: AHB-Lite slave to APB4 master bridge. It decodes NUM_SLV equal windows,
// stretches AHB through PREADY, and answers PSLVERR, unmapped addresses and timeouts with ERROR.
module ahb2apb_bridge_p #(
  parameter int          NUM_SLV   = 3,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          WIN_LOG2  = 16,
  parameter int          TIMEOUT   = 0
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic                   HSEL,
  input  logic [31:0]            HADDR,
  input  logic [1:0]             HTRANS,
  input  logic                   HWRITE,
  input  logic [2:0]             HSIZE,
  input  logic [31:0]            HWDATA,
  input  logic                   HREADY,
  output logic                   HREADYOUT,
  output logic [1:0]             HRESP,
  output logic [31:0]            HRDATA,
  output logic [31:0]            PADDR,
  output logic [NUM_SLV-1:0]     PSEL,
  output logic                   PENABLE,
  output logic                   PWRITE,
  output logic [31:0]            PWDATA,
  output logic [3:0]             PSTRB,
  input  logic [32*NUM_SLV-1:0]  PRDATA,
  input  logic [NUM_SLV-1:0]     PREADY,
  input  logic [NUM_SLV-1:0]     PSLVERR
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SETUP, ST_ACCESS, ST_DONE, ST_ERR1, ST_ERR2
  } state_t;

  localparam logic [31:0] HI_MASK   = ~((32'd1 << (WIN_LOG2 + 4)) - 32'd1);
  localparam logic [4:0]  NUM_SLV_W = 5'(NUM_SLV);
  localparam logic [15:0] TO_LAST   = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        write_q, write_d;
  logic [2:0]  size_q, size_d;
  logic [3:0]  idx_q, idx_d;
  logic [31:0] pwdata_q, pwdata_d;
  logic [31:0] hrdata_q, hrdata_d;
  logic [15:0] tcnt_q, tcnt_d;

  logic        bus_ready;
  logic        accept;
  logic        mapped;
  logic [3:0]  hit_idx;
  logic        apb_active;
  logic [15:0] pready_all;
  logic [15:0] pslverr_all;
  logic [511:0] prdata_all;
  logic        sel_pready;
  logic        sel_pslverr;
  logic [31:0] sel_prdata;
  logic        unused_htrans0;

  // Zero-extend the per-slave buses so a 4-bit index always selects cleanly.
  assign pready_all     = 16'(PREADY);
  assign pslverr_all    = 16'(PSLVERR);
  assign prdata_all     = 512'(PRDATA);
  assign sel_pready     = pready_all[idx_q];
  assign sel_pslverr    = pslverr_all[idx_q];
  assign sel_prdata     = prdata_all[{idx_q, 5'd0} +: 32];
  assign unused_htrans0 = HTRANS[0];

  assign bus_ready = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR2);
  assign accept    = HSEL && HREADY && HTRANS[1] && bus_ready;
  assign hit_idx   = HADDR[WIN_LOG2 +: 4];
  assign mapped    = ((HADDR & HI_MASK) == (BASE_ADDR & HI_MASK)) && ({1'b0, hit_idx} < NUM_SLV_W);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    write_d  = write_q;
    size_d   = size_q;
    idx_d    = idx_q;
    pwdata_d = pwdata_q;
    hrdata_d = hrdata_q;
    tcnt_d   = tcnt_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR2: begin
        state_d = ST_IDLE;
        if (accept) begin
          addr_d  = HADDR;
          write_d = HWRITE;
          size_d  = HSIZE;
          idx_d   = hit_idx;
          state_d = mapped ? ST_SETUP : ST_ERR1;
        end
      end
      ST_SETUP: begin
        state_d  = ST_ACCESS;
        pwdata_d = HWDATA;
        tcnt_d   = 16'd0;
      end
      ST_ACCESS: begin
        tcnt_d = tcnt_q + 16'd1;
        // A ready slave always wins over the timeout in the same cycle.
        if (sel_pready) begin
          if (sel_pslverr) begin
            state_d = ST_ERR1;
          end else begin
            state_d = ST_DONE;
            if (!write_q) hrdata_d = sel_prdata;
          end
        end else if ((TIMEOUT != 0) && (tcnt_q == TO_LAST)) begin
          state_d = ST_ERR1;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= ST_IDLE;
      addr_q   <= 32'd0;
      write_q  <= 1'b0;
      size_q   <= 3'd0;
      idx_q    <= 4'd0;
      pwdata_q <= 32'd0;
      hrdata_q <= 32'd0;
      tcnt_q   <= 16'd0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      size_q   <= size_d;
      idx_q    <= idx_d;
      pwdata_q <= pwdata_d;
      hrdata_q <= hrdata_d;
      tcnt_q   <= tcnt_d;
    end
  end

  assign apb_active = (state_q == ST_SETUP) || (state_q == ST_ACCESS);

  always_comb begin
    PSEL = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      PSEL[i] = apb_active && (idx_q == 4'(i));
    end
  end

  always_comb begin
    PSTRB = 4'b0000;
    if (write_q) begin
      case (size_q)
        3'd0:    PSTRB = 4'b0001 << addr_q[1:0];
        3'd1:    PSTRB = 4'b0011 << {addr_q[1], 1'b0};
        default: PSTRB = 4'b1111;
      endcase
    end
  end

  assign HREADYOUT = bus_ready;
  assign HRESP     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? 2'b01 : 2'b00;
  assign HRDATA    = hrdata_q;
  assign PENABLE   = (state_q == ST_ACCESS);
  assign PADDR     = addr_q;
  assign PWRITE    = write_q;
  assign PWDATA    = (state_q == ST_SETUP) ? HWDATA : pwdata_q;

endmodule

// File: tb/tb_ahb2apb_bridge_p.sv
// tb_ahb2apb_bridge_p: randomized AHB traffic against a transaction-level model, with a
// scoreboard monitor checking AHB responses and APB transfers independently of the driver.
module tb_ahb2apb_bridge_p;

  localparam int          NUM_SLV = 3;
  localparam int          TIMEOUT = 8;
  localparam logic [31:0] BASE    = 32'h8000_0000;

  logic                  HCLK = 1'b0;
  logic                  HRESETn = 1'b0;
  logic                  HSEL, HWRITE;
  logic [31:0]           HADDR, HWDATA;
  logic [1:0]            HTRANS;
  logic [2:0]            HSIZE;
  wire                   HREADY;
  logic                  HREADYOUT;
  logic [1:0]            HRESP;
  logic [31:0]           HRDATA, PADDR, PWDATA;
  logic [NUM_SLV-1:0]    PSEL, PREADY, PSLVERR;
  logic                  PENABLE, PWRITE;
  logic [3:0]            PSTRB;
  logic [32*NUM_SLV-1:0] PRDATA;

  ahb2apb_bridge_p #(
    .NUM_SLV(NUM_SLV), .BASE_ADDR(BASE), .WIN_LOG2(16), .TIMEOUT(TIMEOUT)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA), .PADDR(PADDR),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 HCLK = ~HCLK;
  assign HREADY = HREADYOUT;

  // APB slave model: ready after cur_wait low ACCESS cycles, error flag per transfer.
  logic [31:0] slv_data [NUM_SLV];
  int          cur_wait = 0;
  bit          cur_err = 1'b0;
  int          acc_cnt = 0;

  always @(posedge HCLK) begin
    if (PENABLE) acc_cnt <= acc_cnt + 1;
    else         acc_cnt <= 0;
  end

  always_comb begin
    PREADY  = '0;
    PSLVERR = '0;
    PRDATA  = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      PREADY[i]         = PSEL[i] && PENABLE && (acc_cnt >= cur_wait);
      PSLVERR[i]        = PREADY[i] && cur_err;
      PRDATA[32*i +: 32] = slv_data[i];
    end
  end

  typedef struct {
    bit          err;
    int          lat;
    logic [31:0] rdata;
  } ahb_exp_t;

  typedef struct {
    logic [31:0]        addr;
    logic               wr;
    logic [3:0]         strb;
    logic [31:0]        wdata;
    logic [NUM_SLV-1:0] sel;
    int                 n;
  } apb_exp_t;

  ahb_exp_t    ahb_q[$];
  apb_exp_t    apb_q[$];
  logic [31:0] last_rdata = 32'd0;
  bit          mon_en = 1'b0;
  int          checks = 0;
  int          passes = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic reportFail(input string name);
    checks++;
    $display("[TB] FAIL %s: expected event did not occur as required at %0t", name, $time);
  endtask

  task automatic finishRun();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  endtask

  task automatic waitAccept();
    bit ok;
    int n;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 300) begin
      @(negedge HCLK);
      ok = HREADYOUT;
      @(posedge HCLK);
      n++;
    end
    if (!ok) begin
      reportFail("accept_timeout");
      finishRun();
    end
    #1;
  endtask

  // Reference model: outcome derived from the address map and slave behaviour only.
  task automatic applyStimulus(input logic [31:0] a, input logic wr, input logic [2:0] sz,
                               input logic [31:0] wd, input int wt, input bit er,
                               input logic [31:0] rd);
    ahb_exp_t e;
    apb_exp_t p;
    bit       mapped, timed_out;
    int       slot, n, bytes;
    slot   = int'((a >> 16) & 32'hF);
    mapped = ((a >> 20) == (BASE >> 20)) && (slot < NUM_SLV);
    if (!mapped) begin
      e.err = 1'b1;
      e.lat = 2;
    end else begin
      timed_out = (wt >= TIMEOUT);
      n         = timed_out ? TIMEOUT : wt + 1;
      e.err     = timed_out || er;
      e.lat     = 2 + n + (e.err ? 1 : 0);
      if (!e.err && !wr) last_rdata = rd;
      bytes   = 1 << sz;
      p.addr  = a;
      p.wr    = wr;
      p.strb  = wr ? 4'(((1 << bytes) - 1) << (a & 32'h3)) : 4'b0000;
      p.wdata = wd;
      p.sel   = NUM_SLV'(1 << slot);
      p.n     = n;
      apb_q.push_back(p);
    end
    e.rdata = last_rdata;
    ahb_q.push_back(e);

    HSEL   = 1'b1;
    HADDR  = a;
    HWRITE = wr;
    HSIZE  = sz;
    HTRANS = 2'b10;
    waitAccept();
    HTRANS   = 2'b00;
    HWDATA   = wd;
    cur_wait = wt;
    cur_err  = er;
    for (int i = 0; i < NUM_SLV; i++) slv_data[i] = $urandom;
    if (mapped) slv_data[slot] = rd;
  endtask

  task automatic idleCycles(input int k);
    for (int i = 0; i < k; i++) begin
      case ($urandom_range(0, 2))
        0:       begin HSEL = 1'b0; HTRANS = 2'b10; end
        1:       begin HSEL = 1'b1; HTRANS = 2'b00; end
        default: begin HSEL = 1'b1; HTRANS = 2'b01; end
      endcase
      HADDR = $urandom;
      @(posedge HCLK);
      #1;
    end
    HSEL   = 1'b1;
    HTRANS = 2'b00;
  endtask

  // Scoreboard monitor: pops expectations when the DUT completes an AHB or APB transfer.
  int          cyc = 0;
  int          acc_cyc = 0;
  int          acc_seen = 0;
  bit          pending = 1'b0;
  bit          idle_prev = 1'b0;
  bit          was_en = 1'b0;
  logic [1:0]  prev_hresp = 2'b00;
  logic        prev_hrdy = 1'b1;

  always @(negedge HCLK) begin
    ahb_exp_t e;
    apb_exp_t p;
    bit       accept, completed;
    cyc++;
    if (!mon_en) begin
      pending   = 1'b0;
      idle_prev = 1'b0;
      was_en    = 1'b0;
      acc_seen  = 0;
    end else begin
      accept    = HSEL && HTRANS[1] && HREADYOUT;
      completed = 1'b0;
      if (idle_prev) begin
        checkOutput("idle_hreadyout", 32'(HREADYOUT), 32'd1);
        checkOutput("idle_hresp", 32'(HRESP), 32'd0);
        checkOutput("idle_psel", 32'(PSEL), 32'd0);
      end
      if (pending && HREADYOUT) begin
        completed = 1'b1;
        if (ahb_q.size() == 0) begin
          reportFail("ahb_unexpected_completion");
        end else begin
          e = ahb_q.pop_front();
          checkOutput("latency", 32'(cyc - acc_cyc), 32'(e.lat));
          checkOutput("hresp", 32'(HRESP), e.err ? 32'd1 : 32'd0);
          checkOutput("hrdata", HRDATA, e.rdata);
          if (e.err) begin
            checkOutput("err1_hresp", 32'(prev_hresp), 32'd1);
            checkOutput("err1_hreadyout", 32'(prev_hrdy), 32'd0);
          end
        end
      end else if (pending && (cyc - acc_cyc > 200)) begin
        reportFail("completion_timeout");
        pending = 1'b0;
      end
      if (accept) begin
        pending = 1'b1;
        acc_cyc = cyc;
      end else if (completed) begin
        pending = 1'b0;
      end
      idle_prev  = HREADYOUT && !accept;
      prev_hresp = HRESP;
      prev_hrdy  = HREADYOUT;

      if (PENABLE) begin
        acc_seen++;
        if (apb_q.size() > 0) begin
          checkOutput("psel_access", 32'(PSEL), 32'(apb_q[0].sel));
          if (apb_q[0].wr) checkOutput("pwdata_access", PWDATA, apb_q[0].wdata);
        end
      end else if (was_en) begin
        if (apb_q.size() == 0) begin
          reportFail("apb_unexpected_access");
        end else begin
          p = apb_q.pop_front();
          checkOutput("access_cycles", 32'(acc_seen), 32'(p.n));
        end
        acc_seen = 0;
      end
      if ((PSEL != '0) && !PENABLE) begin
        if (apb_q.size() == 0) begin
          reportFail("apb_unexpected_setup");
        end else begin
          p = apb_q[0];
          checkOutput("psel_setup", 32'(PSEL), 32'(p.sel));
          checkOutput("paddr", PADDR, p.addr);
          checkOutput("pwrite", 32'(PWRITE), 32'(p.wr));
          checkOutput("pstrb", 32'(PSTRB), 32'(p.strb));
          if (p.wr) checkOutput("pwdata_setup", PWDATA, p.wdata);
        end
      end
      was_en = PENABLE;
    end
  end

  initial begin
    #500000;
    reportFail("global_timeout");
    finishRun();
  end

  initial begin
    logic [31:0] ra, rslot, roff;
    int          rsz, rwt, n;
    bit          rer, rwr;
    HSEL = 1'b0; HADDR = 32'd0; HTRANS = 2'b00; HWRITE = 1'b0; HSIZE = 3'd0; HWDATA = 32'd0;
    for (int i = 0; i < NUM_SLV; i++) slv_data[i] = 32'd0;

    HRESETn = 1'b0;
    repeat (2) @(posedge HCLK);
    #1;
    checkOutput("rst_hreadyout", 32'(HREADYOUT), 32'd1);
    checkOutput("rst_hresp", 32'(HRESP), 32'd0);
    checkOutput("rst_hrdata", HRDATA, 32'd0);
    checkOutput("rst_paddr", PADDR, 32'd0);
    checkOutput("rst_psel", 32'(PSEL), 32'd0);
    checkOutput("rst_penable", 32'(PENABLE), 32'd0);
    checkOutput("rst_pwrite", 32'(PWRITE), 32'd0);
    checkOutput("rst_pwdata", PWDATA, 32'd0);
    checkOutput("rst_pstrb", 32'(PSTRB), 32'd0);
    HRESETn = 1'b1;
    @(posedge HCLK);
    #1;
    mon_en = 1'b1;

    $display("[TB] directed transfers");
    applyStimulus(32'h8001_0004, 1'b0, 3'd2, $urandom, 0, 1'b0, 32'hA5A5_1234);
    idleCycles(2);
    applyStimulus(32'h8002_0003, 1'b1, 3'd0, 32'h0000_00EE, 3, 1'b0, $urandom);
    idleCycles(1);
    applyStimulus(32'h8000_0010, 1'b0, 3'd2, $urandom, 0, 1'b1, $urandom);
    applyStimulus(32'h8005_0000, 1'b1, 3'd2, $urandom, 0, 1'b0, $urandom);
    applyStimulus(32'h9001_0000, 1'b0, 3'd2, $urandom, 0, 1'b0, $urandom);
    applyStimulus(32'h8001_0008, 1'b0, 3'd2, $urandom, 50, 1'b1, $urandom);
    applyStimulus(32'h8002_0012, 1'b1, 3'd1, $urandom, 7, 1'b0, $urandom);
    applyStimulus(32'h8000_0020, 1'b0, 3'd2, $urandom, 0, 1'b0, 32'h1357_9BDF);
    applyStimulus(32'h8002_0044, 1'b0, 3'd2, $urandom, 1, 1'b0, 32'h2468_ACE0);
    idleCycles(1);

    $display("[TB] randomized transfers");
    for (int k = 0; k < 80; k++) begin
      rslot = $urandom_range(0, 3);
      rsz   = $urandom_range(0, 2);
      roff  = $urandom_range(0, 65535) & ~((32'd1 << rsz) - 32'd1);
      ra    = BASE | (rslot << 16) | roff;
      if ($urandom_range(0, 9) == 0) ra = ra ^ 32'h1000_0000;
      rwt   = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 3));
      rer   = ($urandom_range(0, 5) == 0);
      rwr   = $urandom_range(0, 1);
      applyStimulus(ra, rwr, 3'(rsz), $urandom, rwt, rer, $urandom);
      idleCycles($urandom_range(0, 2));
    end

    n = 0;
    while ((ahb_q.size() != 0 || apb_q.size() != 0) && n < 500) begin
      @(posedge HCLK);
      n++;
    end
    if (ahb_q.size() != 0 || apb_q.size() != 0) reportFail("drain");
    @(posedge HCLK);
    #1;

    $display("[TB] reset during ACCESS");
    mon_en = 1'b0;
    applyStimulus(32'h8001_0000, 1'b0, 3'd2, $urandom, 20, 1'b0, $urandom);
    ahb_q.delete();
    apb_q.delete();
    n = 0;
    while (!PENABLE && n < 20) begin
      @(negedge HCLK);
      n++;
    end
    @(posedge HCLK);
    #2;
    checkOutput("pre_reset_penable", 32'(PENABLE), 32'd1);
    HRESETn = 1'b0;
    #1;
    checkOutput("async_rst_psel", 32'(PSEL), 32'd0);
    checkOutput("async_rst_penable", 32'(PENABLE), 32'd0);
    checkOutput("async_rst_hrdata", HRDATA, 32'd0);
    checkOutput("async_rst_hreadyout", 32'(HREADYOUT), 32'd1);
    checkOutput("async_rst_hresp", 32'(HRESP), 32'd0);
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    finishRun();
  end

endmodule
